// File: rtl/cordic_vector_0_90_pkg.sv
// Shared constants for the first-quadrant CORDIC vectoring block.
// Angle scale, atan table and phase rounding are common with the sine generator.
package cordic_vector_0_90_pkg;

   localparam int ITERS       = 8;
   localparam int CW          = 3;
   localparam int DW          = 8;
   localparam int IW          = 11;
   localparam int ZW          = 12;
   localparam int PW          = 7;
   localparam int MW          = 10;
   localparam int ANGLE_90    = 1024;
   localparam int PHASE_SHIFT = 4;
   localparam int PHASE_MAX   = ANGLE_90 >> PHASE_SHIFT;

   localparam logic [ZW-1:0] ATAN_TAB [ITERS] = '{
      12'd512, 12'd302, 12'd160, 12'd81,
      12'd41,  12'd20,  12'd10,  12'd5
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic logic [PW-1:0] phase_of(
      input logic signed [ZW-1:0] z
   );
      logic signed [ZW:0] r;
      r = ($signed({z[ZW-1], z}) + 13'sd8) >>> PHASE_SHIFT;
      if (r[ZW])
         phase_of = '0;
      else if (r > $signed(13'(PHASE_MAX)))
         phase_of = PW'(PHASE_MAX);
      else
         phase_of = PW'(r);
   endfunction

endpackage

// File: rtl/cordic_vector_0_90_atan_rom.sv
// Arctangent lookup: iteration index to atan(2^-i).
// Units of 90/1024 degree, purely combinational.
module cordic_vector_0_90_atan_rom
   import cordic_vector_0_90_pkg::*;
(
   input  logic [CW-1:0] idx,
   output logic [ZW-1:0] atan
);

   assign atan = ATAN_TAB[idx];

endmodule

// File: rtl/cordic_vector_0_90.sv
// Iterative CORDIC vectoring: (x,y) in first quadrant to phase/magnitude.
// Eight micro-rotations, one per clock, gain left uncompensated.
module cordic_vector_0_90
   import cordic_vector_0_90_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] y_in,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] phase,
   output logic [MW-1:0] magnitude
);

   state_t state_q;
   state_t state_d;

   logic        [IW-1:0] x_q;
   logic signed [IW-1:0] y_q;
   logic signed [ZW-1:0] z_q;
   logic        [CW-1:0] cnt_q;
   logic                 zero_q;

   logic        [IW-1:0] x_nx;
   logic        [IW-1:0] x_sh;
   logic        [IW-1:0] y_abs;
   logic        [IW-1:0] y_sh;
   logic signed [IW-1:0] y_nx;
   logic signed [ZW-1:0] z_nx;
   logic        [ZW-1:0] atan;
   logic                 y_neg;
   logic                 last_iter;

   cordic_vector_0_90_atan_rom u_rom (
      .idx  (cnt_q),
      .atan (atan)
   );

   // One micro-rotation; negative y is shifted by magnitude so it truncates toward zero
   always_comb begin
      y_neg     = y_q[IW-1];
      y_abs     = y_neg ? $unsigned(-y_q) : $unsigned(y_q);
      x_sh      = x_q >> cnt_q;
      y_sh      = y_abs >> cnt_q;
      x_nx      = x_q + y_sh;
      y_nx      = y_neg ? (y_q + $signed(x_sh))
                        : (y_q - $signed(x_sh));
      z_nx      = y_neg ? (z_q - $signed(atan))
                        : (z_q + $signed(atan));
      last_iter = (cnt_q == CW'(ITERS - 1));
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_CALC;
         ST_CALC: if (last_iter) state_d = ST_OUT;
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Datapath: capture, iterate, publish results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         cnt_q     <= '0;
         zero_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         phase     <= '0;
         magnitude <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  x_q    <= IW'(x_in);
                  y_q    <= $signed(IW'(y_in));
                  z_q    <= '0;
                  cnt_q  <= '0;
                  zero_q <= (x_in == '0) && (y_in == '0);
                  busy   <= 1'b1;
               end
            end
            ST_CALC: begin
               x_q   <= x_nx;
               y_q   <= y_nx;
               z_q   <= z_nx;
               cnt_q <= cnt_q + 1'b1;
            end
            ST_OUT: begin
               phase     <= zero_q ? '0 : phase_of(z_q);
               magnitude <= x_q[MW-1:0];
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_0_90.sv
// Self-checking bench for cordic_vector_0_90.
// Reference is floating-point atan2 / hypot with the CORDIC gain.
module tb_cordic_vector_0_90;

   localparam real PI   = 3.14159265358979;
   localparam real GAIN = 1.6468;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] x_in;
   logic [7:0] y_in;
   logic       busy;
   logic       done;
   logic [6:0] phase;
   logic [9:0] magnitude;

   int n_cmp = 0;
   int n_bad = 0;

   cordic_vector_0_90 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .phase     (phase),
      .magnitude (magnitude)
   );

   always #5 clk = ~clk;

   function automatic real ref_phase(input int x, input int y);
      if (x == 0 && y == 0) return 0.0;
      return $atan2(real'(y), real'(x)) * 128.0 / PI;
   endfunction

   function automatic real ref_mag(input int x, input int y);
      return GAIN * $sqrt(real'(x * x + y * y));
   endfunction

   task automatic run_op(input int x, input int y,
                         output int lat, output int ph, output int mg);
      bit got;
      got   = 1'b0;
      lat   = -1;
      ph    = -1;
      mg    = -1;
      x_in  = 8'(x);
      y_in  = 8'(y);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x_in  = 8'($urandom);
      y_in  = 8'($urandom);
      for (int i = 1; i <= 20 && !got; i++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1'b1;
            lat = i;
            ph  = int'(phase);
            mg  = int'(magnitude);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      x_in  = 8'd0;
      y_in  = 8'd0;
      #3;
      n_cmp += 4;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy got %b want 0", busy);
      end
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL reset_done got %b want 0", done);
      end
      if (phase !== 7'd0) begin
         n_bad++; $display("FAIL reset_phase got %0d want 0", phase);
      end
      if (magnitude !== 10'd0) begin
         n_bad++; $display("FAIL reset_mag got %0d want 0", magnitude);
      end
      start = 1'b1;
      x_in  = 8'd50;
      repeat (2) begin
         @(posedge clk); #1;
         n_cmp++;
         if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_start_ignored busy=%b want 0", busy);
         end
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      int tx [5] = '{100, 0, 100, 255, 0};
      int ty [5] = '{0, 100, 100, 255, 0};
      int tp [5] = '{0, 64, 32, 32, 0};
      int tm [5] = '{164, 164, 232, 593, 0};
      int tt [5] = '{1, 1, 1, 2, 0};
      int lat, ph, mg;
      for (int k = 0; k < 5; k++) begin
         run_op(tx[k], ty[k], lat, ph, mg);
         n_cmp += 3;
         if (lat != 9) begin
            n_bad++;
            $display("FAIL dir_latency x=%0d y=%0d got %0d want 9", tx[k], ty[k], lat);
         end
         if (ph != tp[k]) begin
            n_bad++;
            $display("FAIL dir_phase x=%0d y=%0d got %0d want %0d", tx[k], ty[k], ph, tp[k]);
         end
         if (mg < tm[k] - tt[k] || mg > tm[k] + tt[k]) begin
            n_bad++;
            $display("FAIL dir_mag x=%0d y=%0d got %0d want %0d+/-%0d",
                     tx[k], ty[k], mg, tm[k], tt[k]);
         end
      end
   endtask

   task automatic test_hold;
      int lat, ph, mg;
      run_op(100, 100, lat, ph, mg);
      n_cmp++;
      if (lat != 9) begin
         n_bad++; $display("FAIL hold_latency got %0d want 9", lat);
      end
      x_in = 8'd7;
      y_in = 8'd200;
      repeat (5) begin
         @(posedge clk); #1;
         n_cmp += 4;
         if (done !== 1'b0) begin
            n_bad++; $display("FAIL hold_done got %b want 0", done);
         end
         if (busy !== 1'b0) begin
            n_bad++; $display("FAIL hold_busy got %b want 0", busy);
         end
         if (phase !== 7'd32) begin
            n_bad++; $display("FAIL hold_phase got %0d want 32", phase);
         end
         if (magnitude < 10'd231 || magnitude > 10'd233) begin
            n_bad++; $display("FAIL hold_mag got %0d want 232+/-1", magnitude);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit exp_done;
      start = 1'b1;
      x_in  = 8'd100;
      y_in  = 8'd100;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         exp_done = (n % 10 == 9);
         n_cmp += 2;
         if (done !== exp_done) begin
            n_bad++; $display("FAIL b2b_done edge=%0d got %b want %b", n, done, exp_done);
         end
         if (busy !== !exp_done) begin
            n_bad++; $display("FAIL b2b_busy edge=%0d got %b want %b", n, busy, !exp_done);
         end
         if (exp_done) begin
            n_cmp++;
            if (phase !== 7'd32) begin
               n_bad++; $display("FAIL b2b_phase edge=%0d got %0d want 32", n, phase);
            end
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_loopback;
      int x, y, lat, ph, mg;
      for (int a = 0; a <= 64; a++) begin
         x = $rtoi(255.0 * $cos(real'(a) * PI / 128.0) + 0.5);
         y = $rtoi(255.0 * $sin(real'(a) * PI / 128.0) + 0.5);
         run_op(x, y, lat, ph, mg);
         n_cmp += 2;
         if (lat != 9) begin
            n_bad++; $display("FAIL loop_latency a=%0d got %0d want 9", a, lat);
         end
         if (ph < a - 1 || ph > a + 1) begin
            n_bad++; $display("FAIL loop_phase a=%0d got %0d want %0d+/-1", a, ph, a);
         end
      end
   endtask

   task automatic test_random;
      int x, y, lat, ph, mg;
      real rp, rm, d;
      for (int k = 0; k < 24; k++) begin
         do begin
            x = int'($urandom_range(255, 0));
            y = int'($urandom_range(255, 0));
         end while (x * x + y * y < 128 * 128);
         rp = ref_phase(x, y);
         rm = ref_mag(x, y);
         run_op(x, y, lat, ph, mg);
         n_cmp += 3;
         if (lat != 9) begin
            n_bad++; $display("FAIL rnd_latency x=%0d y=%0d got %0d want 9", x, y, lat);
         end
         d = real'(ph) - rp;
         if (d > 2.5 || d < -2.5) begin
            n_bad++;
            $display("FAIL rnd_phase x=%0d y=%0d got %0d want %f+/-2.5", x, y, ph, rp);
         end
         if (real'(mg) < rm - 7.0 || real'(mg) > rm + 2.0) begin
            n_bad++;
            $display("FAIL rnd_mag x=%0d y=%0d got %0d want %f(-7,+2)", x, y, mg, rm);
         end
      end
   endtask

   task automatic test_reset_midcalc;
      int lat, ph, mg;
      x_in  = 8'd100;
      y_in  = 8'd100;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp += 4;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy);
      end
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_done got %b want 0", done);
      end
      if (phase !== 7'd0) begin
         n_bad++; $display("FAIL mid_rst_phase got %0d want 0", phase);
      end
      if (magnitude !== 10'd0) begin
         n_bad++; $display("FAIL mid_rst_mag got %0d want 0", magnitude);
      end
      start = 1'b1;
      x_in  = 8'd100;
      y_in  = 8'd0;
      repeat (6) begin
         @(posedge clk); #1;
         n_cmp += 2;
         if (done !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_nodone got %b want 0", done);
         end
         if (busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_nobusy got %b want 0", busy);
         end
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL post_rst_idle busy=%b want 0", busy);
      end
      run_op(100, 100, lat, ph, mg);
      n_cmp += 3;
      if (lat != 9) begin
         n_bad++; $display("FAIL post_rst_latency got %0d want 9", lat);
      end
      if (ph != 32) begin
         n_bad++; $display("FAIL post_rst_phase got %0d want 32", ph);
      end
      if (mg < 231 || mg > 233) begin
         n_bad++; $display("FAIL post_rst_mag got %0d want 232+/-1", mg);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_hold;
      test_back_to_back;
      test_loopback;
      test_random;
      test_reset_midcalc;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cordic_vector_0_90.md
CORDIC_VECTOR_0_90 -- requirements
Module: CORDIC_vector_0_90

Interface
REQ-001 Parameters: none; iteration count (8) and widths are fixed constants.
REQ-002 CLK  input  1  processing clock, all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 x_in  input  8  unsigned X component, first quadrant.
REQ-006 y_in  input  8  unsigned Y component, first quadrant.
REQ-007 busy  output  1  high from the edge that accepts start until the edge that asserts done.
REQ-008 done  output  1  one-cycle pulse; phase/magnitude valid from this cycle.
REQ-009 phase  output  7  angle, 0 = 0 deg, 64 = 90 deg; same code space as the sine generator address.
REQ-010 magnitude  output  10  unsigned CORDIC magnitude, gain K~1.6468 not compensated.

Function
REQ-011 The block SHALL implement CORDIC vectoring mode, the inverse of the sine generator: (x,y) -> (phase, magnitude).
REQ-012 States SHALL be IDLE, CALC, OUT; IDLE->CALC on start=1; CALC->OUT after 8 iterations; OUT->IDLE unconditionally.
REQ-013 On the accepting edge (edge 0) x_in/y_in SHALL be registered, iteration counter cleared, angle accumulator z cleared.
REQ-014 Edges 1..8 SHALL perform iteration i=0..7: if y>=0 then x+=y>>>i, y-=x>>>i, z+=atan_i; else x-=y>>>i, y+=x>>>i, z-=atan_i (old x,y used on both sides).
REQ-015 Internal x SHALL be 11-bit unsigned, y 11-bit two's complement, shifts arithmetic with truncation.
REQ-016 z SHALL be 12-bit signed in units of 90/1024 deg; atan_i table = 512, 302, 160, 81, 41, 20, 10, 5.
REQ-017 Edge 9 (OUT) SHALL load phase = (z+8)>>4, clamped to 0..64, magnitude = x[9:0], and assert done for exactly one cycle.
REQ-018 Latency SHALL be 9 cycles from start sample to done; next start accepted earliest on edge 10.
REQ-019 start while busy SHALL be ignored; no queuing.
REQ-020 x_in=0 and y_in=0 SHALL yield phase=0, magnitude=0.
REQ-021 phase/magnitude SHALL hold their last values until the next done.
REQ-022 x_in/y_in changes after the accepting edge SHALL not affect the running result.

Reset
REQ-023 RESET low SHALL asynchronously force state IDLE, busy=0, done=0, phase=0, magnitude=0, internal x/y/z/counter=0.
REQ-024 Reset mid-CALC SHALL abort the operation with no done pulse; first start after release SHALL behave as from power-up.
REQ-025 start SHALL be ignored while RESET is low.

Structure
REQ-026 Shared include CORDIC_defs.vh SHALL hold iteration count, data widths, angle scale (1024 per 90 deg) and the atan_i constants, shared with the sine generator.
REQ-027 Sub-module CORDIC_atan_rom SHALL map iteration index (3 bits) to atan_i (12 bits) combinationally.
REQ-028 Datapath and FSM SHALL live in CORDIC_vector_0_90; no other sub-modules.

Verification
REQ-029 Reset released, start with x=100,y=0 -> done 9 cycles later, phase=0, magnitude=164 +/-1.
REQ-030 x=0,y=100 -> phase=64, magnitude=164 +/-1; x=100,y=100 -> phase=32, magnitude=232 +/-1.
REQ-031 x=255,y=255 -> phase=32, magnitude=593 +/-2, no overflow; x=0,y=0 -> phase=0, magnitude=0.
REQ-032 Loopback: for address 0..64 drive x=sin(90-a), y=sin(a) from the sine generator test-vector file -> phase=a +/-1 for every a.
REQ-033 start pulsed every cycle for 30 cycles -> done exactly at cycles 9, 19, 29; busy low only on non-busy cycles.
REQ-034 RESET pulled low at iteration 4 -> busy/done/outputs 0 immediately; start x=100,y=100 after release -> phase=32 at latency 9.
